atm_controller: RTL and testbench
=================================

# atm_controller

- Sequential, parametrised ATM transaction engine.
- Holds a bank of account balances in registers.
- Accepts one request at a time over a valid/ready handshake: inquiry, deposit, withdraw or transfer.
- Checks each request for insufficient funds and overflow, commits it atomically, and returns a status plus the resulting balance over a second valid/ready handshake.
- Sits between the ATM front-end (keypad/select decoding) and the display/result logic, replacing the stand-alone adder/subtractor datapath.

## Interface
Parameters:
- BAL_W, 10, balance and amount width in bits
- ACCT_N, 16, number of accounts
- ACCT_W, $clog2(ACCT_N), account index width
- INIT_BAL, 0, balance loaded into every account at reset
- LOCK_LIMIT, 3, consecutive failed withdrawals before lockout (used only with ATM_LOCKOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, can accept a request
- req_op  in  2  00 inquiry, 01 deposit, 10 withdraw, 11 transfer
- req_acct_s  in  ACCT_W  source / primary account
- req_acct_d  in  ACCT_W  destination account (transfer only)
- req_amount  in  BAL_W  unsigned amount
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_status  out  2  00 OK, 01 INSUFFICIENT, 10 OVERFLOW, 11 INVALID
- rsp_balance  out  BAL_W  balance of req_acct_s after the transaction

## Operation
FSM states: IDLE → CALC → COMMIT → RESP → IDLE.
- **IDLE:** req_ready=1. On req_valid&&req_ready, latch op, accounts and amount; go to CALC.
- **CALC:**
  - Read both accounts.
  - Compute sum and difference at BAL_W+1 bits.
  - Register the status, new source balance and new destination balance.
- **COMMIT:** If status is OK, write the new balances. For a transfer, both accounts are written on the same edge. Go to RESP.
- **RESP:** rsp_valid=1; outputs stay stable. On rsp_ready, go to IDLE.

Per-operation rules:
- **Inquiry:** always OK. No write.
- **Deposit:** bal+amount carries out of BAL_W bits → OVERFLOW, no write.
- **Withdraw:** amount>bal → INSUFFICIENT, no write. amount==bal is allowed and gives 0.
- **Transfer:**
  - acct_s==acct_d → INVALID.
  - Otherwise, source insufficient → INSUFFICIENT. This check has priority over destination overflow.
  - Otherwise, destination overflow → OVERFLOW.
  - Any failure writes neither account.

Other rules:
- Account index ≥ ACCT_N (when ACCT_N is not a power of two) → INVALID.
- An amount of 0 is legal and gives OK with no change.
- On any failure, rsp_balance equals the unchanged balance of acct_s.

## Timing
- **Reset:**
  - rst_n low asynchronously forces IDLE.
  - Outputs: req_ready=1, rsp_valid=0, rsp_status=00, rsp_balance=0.
  - Every balance is set to INIT_BAL.
- **Reset mid-operation:** an in-flight transaction is discarded and no partial commit occurs.
- **Latency:** accept edge E0; balances updated at E2; rsp_valid high from E2. Minimum 4 cycles per transaction.
- **Read-after-write:** a request accepted after RESP sees the committed balances.
- **Inputs:** req_* are sampled only at the accept edge and may change afterwards.
- **Response hold:** while rsp_ready=0, rsp_valid and the response fields hold indefinitely.
- **Request ignored outside IDLE:** req_valid is ignored while not in IDLE. req_ready=0 in CALC, COMMIT and RESP.

## Configuration
- **ATM_LOCKOUT_EN defined:**
  - A per-account failure counter is added, 2 bits minimum.
  - A withdraw or transfer that returns INSUFFICIENT increments the counter of acct_s.
  - An OK withdraw or transfer clears it.
  - At LOCK_LIMIT the account is locked: further withdraw/transfer from it, or transfer into it, returns INVALID.
  - Inquiry and deposit to a locked account still work.
  - Only reset clears a lock.
- **ATM_LOCKOUT_EN undefined:** no counters, no lockout; LOCK_LIMIT is unused.

## Structure
- **Shared package atm_pkg:**
  - Opcode constants (OP_INQ, OP_DEP, OP_WDR, OP_XFR).
  - Status constants (ST_OK, ST_INSUF, ST_OVF, ST_INV).
  - FSM state encoding.
- **Sub-module atm_balance_alu:** combinational. Inputs: source balance, destination balance, amount, op. Outputs: new balances and status. CALC registers its outputs. It reuses the ten-bit adder/subtractor behaviour, generalised to BAL_W.

## Test plan
- **Reset with INIT_BAL=100:** inquiry on accounts 0 and 15 → OK, 100 each; rsp_valid rises exactly 2 edges after accept.
- **Deposit and withdraw:**
  - Deposit 900 to account 3 → OK, 1000.
  - Deposit 24 → OVERFLOW, 1000.
  - Withdraw 1000 → OK, 0.
  - Withdraw 1 → INSUFFICIENT, 0.
- **Transfer:**
  - Transfer 60 from 1 (100) to 2 (100) → OK, 40; then inquiry on 2 → 160.
  - Transfer 1→1 → INVALID.
  - Transfer 50 from 1 → INSUFFICIENT; both accounts unchanged.
- **Backpressure:** hold rsp_ready=0 for 10 cycles with req_valid=1 → req_ready stays 0, response stable, no second request accepted.
- **Reset mid-operation:** assert rst_n low in COMMIT during a deposit of 50 → all balances return to INIT_BAL, rsp_valid=0.
- **ATM_LOCKOUT_EN:** three INSUFFICIENT withdrawals from account 4, then withdraw 0 → INVALID; deposit 10 → OK.

Source files
------------

// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - opcode, status and FSM state encodings shared by the ATM engine.
package atm_pkg;

  localparam logic [1:0] OP_INQ = 2'b00;
  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_WDR = 2'b10;
  localparam logic [1:0] OP_XFR = 2'b11;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_INV   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2,
    S_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/atm_balance_alu.sv
// rtl/atm_balance_alu.sv - combinational add/subtract datapath producing new balances and status.
module atm_balance_alu
  import atm_pkg::*;
#(
  parameter int BAL_W = 10
) (
  input  logic [BAL_W-1:0] src_bal_i,
  input  logic [BAL_W-1:0] dst_bal_i,
  input  logic [BAL_W-1:0] amount_i,
  input  logic [1:0]       op_i,
  output logic [BAL_W-1:0] new_src_o,
  output logic [BAL_W-1:0] new_dst_o,
  output logic [1:0]       status_o
);

  logic [BAL_W:0] sum_s, diff_s, sum_d;

  // Extra top bit is carry for sums and borrow for the difference.
  assign sum_s  = {1'b0, src_bal_i} + {1'b0, amount_i};
  assign diff_s = {1'b0, src_bal_i} - {1'b0, amount_i};
  assign sum_d  = {1'b0, dst_bal_i} + {1'b0, amount_i};

  always_comb begin
    new_src_o = src_bal_i;
    new_dst_o = dst_bal_i;
    status_o  = ST_OK;
    case (op_i)
      OP_DEP: begin
        if (sum_s[BAL_W]) status_o = ST_OVF;
        else              new_src_o = sum_s[BAL_W-1:0];
      end
      OP_WDR: begin
        if (diff_s[BAL_W]) status_o = ST_INSUF;
        else               new_src_o = diff_s[BAL_W-1:0];
      end
      OP_XFR: begin
        if (diff_s[BAL_W])     status_o = ST_INSUF;
        else if (sum_d[BAL_W]) status_o = ST_OVF;
        else begin
          new_src_o = diff_s[BAL_W-1:0];
          new_dst_o = sum_d[BAL_W-1:0];
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/atm_controller.sv
// rtl/atm_controller.sv - ATM transaction engine with register-file balances.
// Optional per-account failed-withdrawal lockout enabled by ATM_LOCKOUT_EN.
module atm_controller
  import atm_pkg::*;
#(
  parameter int BAL_W      = 10,
  parameter int ACCT_N     = 16,
  parameter int ACCT_W     = $clog2(ACCT_N),
  parameter int INIT_BAL   = 0,
  parameter int LOCK_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ACCT_W-1:0] req_acct_s,
  input  logic [ACCT_W-1:0] req_acct_d,
  input  logic [BAL_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [1:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_balance
);

  localparam logic [BAL_W-1:0] INIT_V   = BAL_W'(INIT_BAL);
  localparam logic [31:0]      ACCT_N_U = 32'(ACCT_N);

  state_e            state_q;
  logic [1:0]        op_q, status_q, rsp_status_q;
  logic [ACCT_W-1:0] acct_s_q, acct_d_q;
  logic [BAL_W-1:0]  amt_q, new_s_q, new_d_q, rsp_balance_q;
  logic [BAL_W-1:0]  bal_q [ACCT_N];
  logic              req_ready_q, rsp_valid_q;

  logic              s_oor, d_oor, lock_s, lock_d, inv_d;
  logic [BAL_W-1:0]  bal_s, bal_d, alu_new_s, alu_new_d;
  logic [1:0]        alu_status;

  assign s_oor = 32'(acct_s_q) >= ACCT_N_U;
  assign d_oor = 32'(acct_d_q) >= ACCT_N_U;
  assign bal_s = s_oor ? '0 : bal_q[acct_s_q];
  assign bal_d = d_oor ? '0 : bal_q[acct_d_q];

  // INVALID outranks any arithmetic outcome.
  assign inv_d = s_oor
              || (((op_q == OP_WDR) || (op_q == OP_XFR)) && lock_s)
              || ((op_q == OP_XFR) && (d_oor || (acct_s_q == acct_d_q) || lock_d));

  atm_balance_alu #(.BAL_W(BAL_W)) u_alu (
    .src_bal_i (bal_s),
    .dst_bal_i (bal_d),
    .amount_i  (amt_q),
    .op_i      (op_q),
    .new_src_o (alu_new_s),
    .new_dst_o (alu_new_d),
    .status_o  (alu_status)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_INQ;
      acct_s_q      <= '0;
      acct_d_q      <= '0;
      amt_q         <= '0;
      status_q      <= ST_OK;
      new_s_q       <= '0;
      new_d_q       <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_status_q  <= ST_OK;
      rsp_balance_q <= '0;
      for (int i = 0; i < ACCT_N; i++) bal_q[i] <= INIT_V;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            acct_s_q    <= req_acct_s;
            acct_d_q    <= req_acct_d;
            amt_q       <= req_amount;
            req_ready_q <= 1'b0;
            state_q     <= S_CALC;
          end
        end
        S_CALC: begin
          status_q <= inv_d ? ST_INV : alu_status;
          new_s_q  <= inv_d ? bal_s : alu_new_s;
          new_d_q  <= alu_new_d;
          state_q  <= S_COMMIT;
        end
        S_COMMIT: begin
          if ((status_q == ST_OK) && (op_q != OP_INQ)) begin
            bal_q[acct_s_q] <= new_s_q;
            if (op_q == OP_XFR) bal_q[acct_d_q] <= new_d_q;
          end
          rsp_valid_q   <= 1'b1;
          rsp_status_q  <= status_q;
          rsp_balance_q <= new_s_q;
          state_q       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef ATM_LOCKOUT_EN
  localparam int CNT_W = (LOCK_LIMIT < 4) ? 2 : $clog2(LOCK_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LOCK_LIMIT);

  logic [CNT_W-1:0] fail_q [ACCT_N];

  assign lock_s = !s_oor && (fail_q[acct_s_q] >= LIM);
  assign lock_d = !d_oor && (fail_q[acct_d_q] >= LIM);

  // Counter saturates at the limit; once locked only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ACCT_N; i++) fail_q[i] <= '0;
    end else if ((state_q == S_COMMIT) && ((op_q == OP_WDR) || (op_q == OP_XFR))) begin
      if ((status_q == ST_INSUF) && (fail_q[acct_s_q] < LIM))
        fail_q[acct_s_q] <= fail_q[acct_s_q] + 1'b1;
      else if (status_q == ST_OK)
        fail_q[acct_s_q] <= '0;
    end
  end
`else
  logic unused_lock;
  assign lock_s      = 1'b0;
  assign lock_d      = 1'b0;
  assign unused_lock = (LOCK_LIMIT != 0);
`endif

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_controller.sv
// tb/tb_atm_controller.sv - self-checking bench for atm_controller against a behavioural account model.
module tb_atm_controller;

  localparam int MAXB     = 1023;
  localparam int INIT     = 100;
  localparam int ST_OK    = 0;
  localparam int ST_INSUF = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_INV   = 3;
`ifdef ATM_LOCKOUT_EN
  localparam int LIMIT    = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, rsp_valid, rsp_ready;
  logic [1:0] req_op, rsp_status;
  logic [3:0] req_acct_s, req_acct_d;
  logic [9:0] req_amount, rsp_balance;

  int n_vec = 0;
  int n_err = 0;
  int mbal  [16];
  int mfail [16];

  always #5 clk = ~clk;

  atm_controller #(
    .BAL_W(10), .ACCT_N(16), .ACCT_W(4), .INIT_BAL(100), .LOCK_LIMIT(3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_acct_s  (req_acct_s),
    .req_acct_d  (req_acct_d),
    .req_amount  (req_amount),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_status  (rsp_status),
    .rsp_balance (rsp_balance)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mbal[i]  = INIT;
      mfail[i] = 0;
    end
  endtask

  task automatic model(input int op, input int s, input int d, input int amt,
                       output int st, output int bal);
    bit lk_s, lk_d;
    lk_s = 1'b0;
    lk_d = 1'b0;
`ifdef ATM_LOCKOUT_EN
    lk_s = mfail[s] >= LIMIT;
    lk_d = mfail[d] >= LIMIT;
`endif
    st = ST_OK;
    case (op)
      1: if (mbal[s] + amt > MAXB) st = ST_OVF; else mbal[s] += amt;
      2: if (lk_s) st = ST_INV;
         else if (amt > mbal[s]) st = ST_INSUF;
         else mbal[s] -= amt;
      3: if (s == d || lk_s || lk_d) st = ST_INV;
         else if (amt > mbal[s]) st = ST_INSUF;
         else if (mbal[d] + amt > MAXB) st = ST_OVF;
         else begin
           mbal[s] -= amt;
           mbal[d] += amt;
         end
      default: ;
    endcase
    if (op >= 2) begin
      if (st == ST_INSUF) mfail[s]++;
      else if (st == ST_OK) mfail[s] = 0;
    end
    bal = mbal[s];
  endtask

  task automatic txn(input string tag, input int op, input int s, input int d, input int amt,
                     output int st, output int bal);
    int guard, lat, est, ebal;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "/ready"}, int'(req_ready), 1);
    req_valid  = 1'b1;
    req_op     = 2'(op);
    req_acct_s = 4'(s);
    req_acct_d = 4'(d);
    req_amount = 10'(amt);
    @(posedge clk); #1;
    req_valid  = 1'($urandom);
    req_op     = 2'($urandom);
    req_acct_s = 4'($urandom);
    req_acct_d = 4'($urandom);
    req_amount = 10'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/lat"}, lat, 2);
    st  = int'(rsp_status);
    bal = int'(rsp_balance);
    model(op, s, d, amt, est, ebal);
    check({tag, "/st"}, st, est);
    check({tag, "/bal"}, bal, ebal);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int st, bal, est, ebal, guard;
    int op, s, d, amt;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_acct_s = '0; req_acct_d = '0; req_amount = '0;
    model_reset();
    #12;
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_status", int'(rsp_status), 0);
    check("rst_rsp_balance", int'(rsp_balance), 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    txn("inq0", 0, 0, 0, 0, st, bal);     check("inq0_100", bal, 100);
    txn("inq15", 0, 15, 0, 0, st, bal);   check("inq15_100", bal, 100);
    txn("dep900", 1, 3, 0, 900, st, bal); check("dep900_bal", bal, 1000);
    txn("dep24", 1, 3, 0, 24, st, bal);   check("dep24_ovf", st, ST_OVF);
    txn("wdr1000", 2, 3, 0, 1000, st, bal); check("wdr1000_bal", bal, 0);
    txn("wdr1", 2, 3, 0, 1, st, bal);     check("wdr1_insuf", st, ST_INSUF);
    txn("xfr60", 3, 1, 2, 60, st, bal);   check("xfr60_bal", bal, 40);
    txn("inq2", 0, 2, 0, 0, st, bal);     check("inq2_160", bal, 160);
    txn("xfr11", 3, 1, 1, 10, st, bal);   check("xfr11_inv", st, ST_INV);
    txn("xfr50", 3, 1, 2, 50, st, bal);   check("xfr50_insuf", st, ST_INSUF);
    txn("inq1b", 0, 1, 0, 0, st, bal);    check("inq1_40", bal, 40);
    txn("inq2b", 0, 2, 0, 0, st, bal);    check("inq2_160b", bal, 160);
    txn("dep0", 1, 5, 0, 0, st, bal);     check("dep0_ok", st, ST_OK);

`ifdef ATM_LOCKOUT_EN
    for (int k = 0; k < 3; k++) txn("lk_wdr", 2, 4, 0, 200, st, bal);
    txn("lk_wdr0", 2, 4, 0, 0, st, bal);  check("lk_wdr0_inv", st, ST_INV);
    txn("lk_dep10", 1, 4, 0, 10, st, bal); check("lk_dep10_ok", st, ST_OK);
    check("lk_dep10_bal", bal, 110);
`endif

    // Backpressure: response held while a second request sits on the bus.
    req_valid = 1'b1; req_op = 2'd1; req_acct_s = 4'd6; req_acct_d = 4'd0; req_amount = 10'd7;
    @(posedge clk); #1;
    req_amount = 10'd100;
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    model(1, 6, 0, 7, est, ebal);
    check("bp_st", int'(rsp_status), est);
    check("bp_bal0", int'(rsp_balance), ebal);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("bp_req_ready", int'(req_ready), 0);
      check("bp_rsp_valid", int'(rsp_valid), 1);
      check("bp_rsp_bal", int'(rsp_balance), ebal);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    txn("bp_inq", 0, 6, 0, 0, st, bal);   check("bp_inq_107", bal, 107);

    for (int n = 0; n < 200; n++) begin
      op = $urandom_range(0, 3);
      s  = $urandom_range(0, 15);
      d  = ($urandom_range(0, 7) == 0) ? s : $urandom_range(0, 15);
      case ($urandom_range(0, 3))
        0:       amt = 0;
        1:       amt = $urandom_range(0, 1023);
        2:       amt = mbal[s];
        default: amt = $urandom_range(0, 200);
      endcase
      txn($sformatf("rnd%0d", n), op, s, d, amt, st, bal);
    end

    // Reset while a deposit sits in COMMIT.
    req_valid = 1'b1; req_op = 2'd1; req_acct_s = 4'd7; req_amount = 10'd50;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", int'(rsp_valid), 0);
    check("mid_rst_req_ready", int'(req_ready), 1);
    check("mid_rst_rsp_bal", int'(rsp_balance), 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      txn($sformatf("post_rst%0d", i), 0, i, 0, 0, st, bal);
      check($sformatf("post_rst_bal%0d", i), bal, INIT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
